// File: rtl/inst_align_buffer_pkg.sv
// Shared opcode and predecode-class definitions for the fetch/decode boundary.
// Used by the align buffer, the decoder and the hazard unit.
package inst_align_buffer_pkg;

   // Major opcode field inst[6:2]
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_JUMP   = 3'd4,
      CLS_SYSTEM = 3'd5,
      CLS_OTHER  = 3'd7
   } inst_class_e;

   localparam int PARCEL_W = 16;

endpackage

// File: rtl/inst_predecode.sv
// Combinational predecode: maps the major opcode and instruction length of the
// head instruction to a coarse class and an illegal flag for 16-bit encodings.
module inst_predecode
   import inst_align_buffer_pkg::*;
#(
   parameter int ENABLE_RVC = 1
) (
   input  logic [4:0] opcode,
   input  logic       len32,
   output logic [2:0] cls,
   output logic       illegal
);

   localparam logic RVC_OFF = (ENABLE_RVC == 0);

   always_comb begin
      cls = CLS_OTHER;
      if (len32) begin
         case (opcode)
            OP_R, OP_IMM, OP_LUI, OP_AUIPC: cls = CLS_ALU;
            OP_LOAD:                        cls = CLS_LOAD;
            OP_STORE:                       cls = CLS_STORE;
            OP_BRANCH:                      cls = CLS_BRANCH;
            OP_JAL, OP_JALR:                cls = CLS_JUMP;
            OP_SYSTEM:                      cls = CLS_SYSTEM;
            default:                        cls = CLS_OTHER;
         endcase
      end
   end

   assign illegal = !len32 && RVC_OFF;

endmodule

// File: rtl/inst_align_buffer.sv
// Parcel-granular circular buffer between fetch and decode; presents one aligned
// 16- or 32-bit instruction per handshake with its PC, length and predecode class.
module inst_align_buffer
   import inst_align_buffer_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int PC_W       = 32,
   parameter int ENABLE_RVC = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [PC_W-1:0]           flush_pc,
   input  logic                      fetch_valid,
   output logic                      fetch_ready,
   input  logic [31:0]               fetch_data,
   output logic                      dec_valid,
   input  logic                      dec_ready,
   output logic [31:0]               dec_inst,
   output logic [PC_W-1:0]           dec_pc,
   output logic                      dec_len32,
   output logic [2:0]                dec_class,
   output logic                      dec_illegal,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] PUSH_LIM = CNT_W'(DEPTH - 2);

   logic [PARCEL_W-1:0] parcel_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [PTR_W-1:0]    wr_ptr_nx1, rd_ptr_nx1;
   logic [CNT_W-1:0]    count;
   logic [PC_W-1:0]     pc_q;
   logic                drop_low;

   logic [PARCEL_W-1:0] p0, p1;
   logic                head32;
   logic                push, pop;
   logic [1:0]          push_n, pop_n;

   assign wr_ptr_nx1 = wr_ptr + PTR_W'(1);
   assign rd_ptr_nx1 = rd_ptr + PTR_W'(1);

   // Head assembly; wrap from index DEPTH-1 to 0 falls out of the pointer width
   assign p0     = parcel_q[rd_ptr];
   assign p1     = parcel_q[rd_ptr_nx1];
   assign head32 = (p0[1:0] == 2'b11);

   assign fetch_ready = (count <= PUSH_LIM);
   assign dec_valid   = head32 ? (count >= CNT_W'(2)) : (count >= CNT_W'(1));
   assign dec_inst    = head32 ? {p1, p0} : {16'h0000, p0};
   assign dec_len32   = head32;
   assign dec_pc      = pc_q;
   assign occupancy   = count;

   assign push   = fetch_valid && fetch_ready && !flush;
   assign pop    = dec_valid && dec_ready && !flush;
   assign push_n = !push ? 2'd0 : (drop_low ? 2'd1 : 2'd2);
   assign pop_n  = !pop  ? 2'd0 : (head32   ? 2'd2 : 2'd1);

   inst_predecode #(
      .ENABLE_RVC (ENABLE_RVC)
   ) u_predecode (
      .opcode  (dec_inst[6:2]),
      .len32   (head32),
      .cls     (dec_class),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pc_q     <= '0;
         drop_low <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pc_q     <= flush_pc & ~PC_W'(1);
         drop_low <= flush_pc[1];
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_n);
         rd_ptr <= rd_ptr + PTR_W'(pop_n);
         count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
         pc_q   <= pc_q + PC_W'({pop_n, 1'b0});
         if (push) drop_low <= 1'b0;
      end
   end

   // Parcel storage holds data only and needs no reset
   always_ff @(posedge clk) begin
      if (push) begin
         if (drop_low) begin
            parcel_q[wr_ptr] <= fetch_data[31:16];
         end else begin
            parcel_q[wr_ptr]     <= fetch_data[15:0];
            parcel_q[wr_ptr_nx1] <= fetch_data[31:16];
         end
      end
   end

endmodule
